bin_to_7seg_converter: RTL and testbench



---
 rtl/bin_to_7seg_converter_pkg.sv | 24 ++
 rtl/seven_seg_encoder.sv | 26 ++
 rtl/bin_to_7seg_converter.sv | 140 ++++++++++++++
 tb/tb_bin_to_7seg_converter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_7seg_converter_pkg.sv
// Shared constants for the binary-to-seven-segment display stage:
// active-low segment patterns {g,f,e,d,c,b,a} and FSM state encodings.
package bin_to_7seg_converter_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module seven_seg_encoder
  import bin_to_7seg_converter_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_7seg_converter.sv
// Iterative double-dabble converter, one input bit per clock, driving four
// active-low seven-segment digits; values above 9999 display as dashes.
module bin_to_7seg_converter
  import bin_to_7seg_converter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic [WIDTH-1:0] binary,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       ones,
  output logic [6:0]       tens,
  output logic [6:0]       hundreds,
  output logic [6:0]       thousands
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [6:0]       ones_q, ones_d, tens_q, tens_d;
  logic [6:0]       hundreds_q, hundreds_d, thousands_q, thousands_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic [6:0]       seg_enc [4];

  for (genvar g = 0; g < 4; g++) begin : gen_enc
    seven_seg_encoder u_enc (
      .nibble_i (bcd_q[4*g +: 4]),
      .seg_o    (seg_enc[g])
    );
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bcd_d       = bcd_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    hundreds_d  = hundreds_q;
    thousands_d = thousands_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = binary;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CntW'(WIDTH);
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        // Anything shifted out of the thousands nibble means value > 9999.
        carry_d = carry_q | bcd_adj[15];
        bcd_d   = {bcd_adj[14:0], shreg_q[WIDTH-1]};
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (carry_q) begin
          ones_d      = SEG_DASH;
          tens_d      = SEG_DASH;
          hundreds_d  = SEG_DASH;
          thousands_d = SEG_DASH;
          overflow_d  = 1'b1;
        end else begin
          ones_d      = seg_enc[0];
          tens_d      = seg_enc[1];
          hundreds_d  = seg_enc[2];
          thousands_d = seg_enc[3];
          overflow_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bcd_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      ones_q      <= SEG_0;
      tens_q      <= SEG_0;
      hundreds_q  <= SEG_0;
      thousands_q <= SEG_0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bcd_q       <= bcd_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      hundreds_q  <= hundreds_d;
      thousands_q <= thousands_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign ones      = ones_q;
  assign tens      = tens_q;
  assign hundreds  = hundreds_q;
  assign thousands = thousands_q;

endmodule

// File: tb/tb_bin_to_7seg_converter.sv
// Self-checking bench: fixed vectors, randomized values against a decimal
// reference model, and multi-cycle handshake/reset sequences.
module tb_bin_to_7seg_converter;

  localparam int unsigned W = 32;

  logic         clk_fpga = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] binary;
  logic         busy, done, overflow;
  logic [6:0]   ones, tens, hundreds, thousands;

  int tests = 0;
  int fails = 0;

  // Digit glyphs written straight from the display encoding table.
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  typedef struct {
    logic [31:0] bin;
    logic [6:0]  th, hu, te, on;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  bin_to_7seg_converter #(.WIDTH(W)) dut (
    .clk_fpga  (clk_fpga),
    .reset     (reset),
    .binary    (binary),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] model_segs(input logic [31:0] v);
    if (v > 32'd9999) return {DASH, DASH, DASH, DASH};
    return {seg_tab[(v / 1000) % 10], seg_tab[(v / 100) % 10],
            seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  // Pulse start for one edge; returns edges from the accept edge to done.
  task automatic run_conv(input logic [31:0] v, output int lat);
    @(negedge clk_fpga);
    binary = v;
    start  = 1'b1;
    @(posedge clk_fpga);
    #1;
    start = 1'b0;
    lat   = 0;
    do begin
      @(posedge clk_fpga);
      #1;
      lat++;
    end while (!done && lat < 100);
  endtask

  task automatic conv_and_check(input string tag, input logic [31:0] v,
                                input logic [6:0] eth, input logic [6:0] ehu,
                                input logic [6:0] ete, input logic [6:0] eon,
                                input logic eovf);
    int lat;
    run_conv(v, lat);
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " thousands"}, 32'(thousands), 32'(eth));
    check({tag, " hundreds"}, 32'(hundreds), 32'(ehu));
    check({tag, " tens"}, 32'(tens), 32'(ete));
    check({tag, " ones"}, 32'(ones), 32'(eon));
    check({tag, " overflow"}, 32'(overflow), 32'(eovf));
    @(posedge clk_fpga);
    #1;
    check({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, n2, dones, busy_bad;
    logic [31:0] v;
    logic [27:0] m;

    vecs[0] = '{32'd0,        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b0};
    vecs[1] = '{32'd1234,     7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 1'b0};
    vecs[2] = '{32'd9999,     7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 1'b0};
    vecs[3] = '{32'd10000,    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 1'b1};
    vecs[5] = '{32'd5678,     7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 1'b0};
    vecs[6] = '{32'd42,       7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(posedge clk_fpga);
    #1;
    reset = 1'b0;

    // Reset then idle: nothing moves.
    n = 0;
    repeat (5) begin
      @(posedge clk_fpga);
      #1;
      if (done) n++;
    end
    check("reset thousands", 32'(thousands), 32'(seg_tab[0]));
    check("reset hundreds", 32'(hundreds), 32'(seg_tab[0]));
    check("reset tens", 32'(tens), 32'(seg_tab[0]));
    check("reset ones", 32'(ones), 32'(seg_tab[0]));
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset no done", 32'(n), 32'd0);

    for (int i = 0; i < 7; i++) begin
      conv_and_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].th, vecs[i].hu,
                     vecs[i].te, vecs[i].on, vecs[i].ovf);
    end

    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       v = $urandom_range(9999, 0);
        1:       v = $urandom_range(10010, 9990);
        2:       v = $urandom();
        default: v = $urandom_range(999, 0);
      endcase
      m = model_segs(v);
      conv_and_check($sformatf("rand%0d(%0d)", i, v), v, m[27:21], m[20:14], m[13:7],
                     m[6:0], v > 32'd9999);
    end

    // Start while busy is ignored: second request with 7 lands at E10.
    @(negedge clk_fpga);
    binary = 32'd5;
    start  = 1'b1;
    @(posedge clk_fpga);
    #1;
    start    = 1'b0;
    binary   = 32'd7;
    dones    = 0;
    busy_bad = 0;
    for (int e = 1; e <= 45; e++) begin
      if (e == 10) start = 1'b1;
      @(posedge clk_fpga);
      #1;
      if (e == 10) start = 1'b0;
      if (done) dones++;
      if (e <= 32 && !busy) busy_bad++;
    end
    check("busy start dones", 32'(dones), 32'd1);
    check("busy start busy held", 32'(busy_bad), 32'd0);
    check("busy start ones", 32'(ones), 32'(seg_tab[5]));
    check("busy start tens", 32'(tens), 32'(seg_tab[0]));

    // Reset mid-conversion aborts with no done pulse.
    @(negedge clk_fpga);
    binary = 32'd1234;
    start  = 1'b1;
    @(posedge clk_fpga);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk_fpga);
    @(negedge clk_fpga);
    reset = 1'b1;
    @(posedge clk_fpga);
    #1;
    reset = 1'b0;
    check("abort ones", 32'(ones), 32'(seg_tab[0]));
    check("abort busy", 32'(busy), 32'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk_fpga);
      #1;
      if (done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort thousands", 32'(thousands), 32'(seg_tab[0]));
    conv_and_check("after abort 42", 32'd42, seg_tab[0], seg_tab[0], seg_tab[4], seg_tab[2],
                   1'b0);

    // Start held high: re-accepted in the done cycle, period WIDTH+2 edges.
    @(negedge clk_fpga);
    binary = 32'd3;
    start  = 1'b1;
    n = 0;
    do begin
      @(posedge clk_fpga);
      #1;
      n++;
    end while (!done && n < 100);
    check("held first latency", 32'(n), 32'd34);
    n2 = 0;
    do begin
      @(posedge clk_fpga);
      #1;
      n2++;
    end while (!done && n2 < 100);
    check("held period", 32'(n2), 32'd34);
    check("held ones", 32'(ones), 32'(seg_tab[3]));
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk_fpga);
      #1;
      n++;
    end
    check("held drains", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
